// File: rtl/inst_prefetch.sv
// Instruction prefetch buffer: credit-limited fetch requests into an in-order FIFO,
// with redirect flush and discard of responses still in flight at the time of a jump.
module inst_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_flag_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o
);
    localparam int          AW  = $clog2(DEPTH);
    localparam int          CW  = AW + 1;
    localparam logic [CW:0] LIM = (CW+1)'(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {RUN, DRAIN} state_t;

    state_t          state, state_nxt;
    logic [31:0]     fetch_pc, head_pc, jump_tgt;
    logic [CW-1:0]   count, outstanding, discard, out_after_rsp;
    logic [CW:0]     credit_used;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [31:0]     mem [DEPTH];
    logic            rsp, grant, push, pop, drop;

    // Every slot not already holding data is reserved for an in-flight response.
    assign credit_used   = {1'b0, count} + {1'b0, outstanding};
    assign ibus_req_o    = rst && !jump_flag_i && (credit_used < LIM);
    assign ibus_addr_o   = fetch_pc;
    assign grant         = ibus_req_o && ibus_gnt_i;
    assign rsp           = ibus_rvalid_i && (outstanding != '0);
    assign out_after_rsp = outstanding - CW'(rsp);
    assign push          = rsp && !drop;
    assign pop           = inst_valid_o && !hold_flag_i && !jump_flag_i;
    assign jump_tgt      = jump_addr_i & ~32'h3;

    assign inst_valid_o  = (count != '0);
    assign inst_o        = inst_valid_o ? mem[rd_ptr] : NOP;
    assign inst_addr_o   = head_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RUN;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (jump_flag_i)
            state_nxt = (out_after_rsp != '0) ? DRAIN : RUN;
        else if (state == DRAIN && drop && discard == CW'(1))
            state_nxt = RUN;
    end

    always_comb begin
        drop = (state == DRAIN) && rsp;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            head_pc     <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            outstanding <= out_after_rsp + CW'(grant);
            if (jump_flag_i) begin
                // Everything still on the bus after this cycle's return belongs to the old stream.
                fetch_pc <= jump_tgt;
                head_pc  <= jump_tgt;
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                discard  <= out_after_rsp;
            end else begin
                if (grant) fetch_pc <= fetch_pc + 32'd4;
                if (pop) begin
                    head_pc <= head_pc + 32'd4;
                    rd_ptr  <= rd_ptr + AW'(1);
                end
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (drop) discard <= discard - CW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !jump_flag_i) mem[wr_ptr] <= ibus_rdata_i;
    end
endmodule
